ram_burst_ctrl: RTL and testbench

//   Upstream sequencer for single_port_ram: accepts burst commands (start address, length, direction)
//   on a valid/ready interface, then issues one single-beat RAM access per beat with incrementing,

---
 rtl/ram_burst_ctrl_pkg.sv | 20 ++
 rtl/ram_burst_ctrl_if.sv | 34 +++
 rtl/ram_burst_addr_gen.sv | 51 +++++
 rtl/single_port_ram.sv | 45 ++++
 rtl/ram_burst_ctrl.sv | 133 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 293 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
// rtl/ram_burst_ctrl_pkg.sv - shared types and default geometry for the burst controller and its RAM
// Purpose: burst FSM state encoding plus the default data width, depth and
//          address width that the controller and single_port_ram must agree on.
// Ports:   none (package).
package ram_burst_ctrl_pkg;

    localparam int W_DEF        = 8;
    localparam int ADDR_LEN_DEF = 4;
    localparam int D_DEF        = 2 ** ADDR_LEN_DEF;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// rtl/ram_burst_ctrl_if.sv - host-side command, write-stream and read-stream bundle
// Purpose: groups the host handshakes of ram_burst_ctrl.
// Ports:   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len  burst command
//          wr_valid/wr_ready/wr_data                    write beat stream
//          rd_valid/rd_ready/rd_data                    read beat stream
//          done                                         burst-complete pulse
//          modport master = host side, slave = controller side
interface ram_burst_ctrl_if #(
    parameter int W        = 8,
    parameter int ADDR_LEN = 4
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_wr;
    logic [ADDR_LEN-1:0] cmd_addr;
    logic [ADDR_LEN:0]   cmd_len;
    logic                wr_valid;
    logic                wr_ready;
    logic [W-1:0]        wr_data;
    logic                rd_valid;
    logic                rd_ready;
    logic [W-1:0]        rd_data;
    logic                done;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, done
    );
endinterface

// File: rtl/ram_burst_addr_gen.sv
// rtl/ram_burst_addr_gen.sv - burst address / remaining-beat counter
// Purpose: loads start address and beat count, steps once per completed beat,
//          wrapping the address from D-1 back to 0.
// Ports:   clk, rst        clock, synchronous active-high reset
//          load_i          capture start_addr_i / len_i
//          start_addr_i    first beat address
//          len_i           beat count (0..D)
//          step_i          one beat completed
//          addr_o          address of the current beat
//          last_o          current beat is the final one
module ram_burst_addr_gen #(
    parameter int D        = 16,
    parameter int ADDR_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [ADDR_LEN-1:0] start_addr_i,
    input  logic [ADDR_LEN:0]   len_i,
    input  logic                step_i,
    output logic [ADDR_LEN-1:0] addr_o,
    output logic                last_o
);
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [ADDR_LEN:0]   rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = start_addr_i;
            rem_d  = len_i;
        end else if (step_i) begin
            addr_d = (addr_q == ADDR_LEN'(D - 1)) ? '0 : addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == (ADDR_LEN + 1)'(1));
endmodule

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - single-port RAM driven by ram_burst_ctrl
// Purpose: synchronous write, read of the (registered) request address so read
//          data is valid in the cycle after the requester issues the read.
// Ports:   clk, rst   clock, synchronous active-high reset (ready flag only)
//          valid      request strobe
//          wrd        write(1)/read(0)
//          address    word address, MSB ignored
//          wdata      write data
//          rdata      read data
//          ready      sticky once the first access has been seen
module single_port_ram
    import ram_burst_ctrl_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int D        = D_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              wrd,
    input  logic [ADDR_LEN:0] address,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata,
    output logic              ready
);
    logic [W-1:0] mem [D];
    logic         ready_q;
    logic         unused_addr_msb;

    assign unused_addr_msb = address[ADDR_LEN];

    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (valid && wrd) mem[address[ADDR_LEN-1:0]] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)        ready_q <= 1'b0;
        else if (valid) ready_q <= 1'b1;
    end

    assign rdata = mem[address[ADDR_LEN-1:0]];
    assign ready = ready_q;
endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst sequencer in front of single_port_ram
// Purpose: accepts burst commands and turns them into one registered RAM
//          access per beat, streaming write beats in and read beats out.
// Ports:   clk, rst        clock, synchronous active-high reset
//          bus             host command / write / read streams (slave side)
//          ram_valid       registered RAM request strobe
//          ram_wrd         registered write(1)/read(0)
//          ram_address     registered RAM address, MSB always 0
//          ram_wdata       registered RAM write data
//          ram_rdata       RAM read data, valid in the cycle after the request is issued
//          ram_ready       RAM ready (informational only)
module ram_burst_ctrl
    import ram_burst_ctrl_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int D        = D_DEF,
    parameter int ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    ram_burst_ctrl_if.slave     bus,
    output logic                ram_valid,
    output logic                ram_wrd,
    output logic [ADDR_LEN:0]   ram_address,
    output logic [W-1:0]        ram_wdata,
    input  logic [W-1:0]        ram_rdata,
    input  logic                ram_ready
);
    state_e              state_q, state_d;
    logic                ram_valid_q, ram_valid_d;
    logic                ram_wrd_q, ram_wrd_d;
    logic [ADDR_LEN-1:0] ram_addr_q, ram_addr_d;
    logic [W-1:0]        ram_wdata_q, ram_wdata_d;
    logic                rd_valid_q;
    logic [W-1:0]        rd_data_q;
    logic                done_q;
    logic                gen_load, gen_step, gen_last;
    logic [ADDR_LEN-1:0] gen_addr;
    logic                unused_ram_ready;

    // Sequencing never waits on the RAM; it is always ready after the first access.
    assign unused_ram_ready = ram_ready;

    ram_burst_addr_gen #(.D(D), .ADDR_LEN(ADDR_LEN)) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .load_i       (gen_load),
        .start_addr_i (bus.cmd_addr),
        .len_i        (bus.cmd_len),
        .step_i       (gen_step),
        .addr_o       (gen_addr),
        .last_o       (gen_last)
    );

    always_comb begin
        state_d     = state_q;
        ram_valid_d = 1'b0;
        ram_wrd_d   = ram_wrd_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        gen_load    = 1'b0;
        gen_step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    gen_load = 1'b1;
                    if (bus.cmd_len == '0)  state_d = DONE;
                    else if (bus.cmd_wr)    state_d = WRITE;
                    else                    state_d = RD_ISSUE;
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    ram_valid_d = 1'b1;
                    ram_wrd_d   = 1'b1;
                    ram_addr_d  = gen_addr;
                    ram_wdata_d = bus.wr_data;
                    gen_step    = 1'b1;
                    if (gen_last) state_d = DONE;
                end
            end
            RD_ISSUE: begin
                ram_valid_d = 1'b1;
                ram_wrd_d   = 1'b0;
                ram_addr_d  = gen_addr;
                state_d     = RD_WAIT;
            end
            RD_WAIT: state_d = RD_HOLD;
            RD_HOLD: begin
                // Address only advances once the host has taken the beat.
                if (bus.rd_ready) begin
                    gen_step = 1'b1;
                    state_d  = gen_last ? DONE : RD_ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_valid_q <= 1'b0;
            ram_wrd_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_valid_q <= ram_valid_d;
            ram_wrd_q   <= ram_wrd_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            // Flags are registered from the next state so they line up with the state itself.
            rd_valid_q  <= (state_d == RD_HOLD);
            done_q      <= (state_d == DONE);
            if (state_q == RD_WAIT) rd_data_q <= ram_rdata;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WRITE);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.done      = done_q;
    assign ram_valid     = ram_valid_q;
    assign ram_wrd       = ram_wrd_q;
    assign ram_address   = {1'b0, ram_addr_q};
    assign ram_wdata     = ram_wdata_q;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - directed self-checking bench for ram_burst_ctrl with single_port_ram
module tb_ram_burst_ctrl;
    localparam int W  = 8;
    localparam int AL = 4;
    localparam int D  = 16;
    localparam int AW = AL + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ram_valid, ram_wrd, ram_ready;
    logic [AL:0]   ram_address;
    logic [W-1:0]  ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [AL:0]  mon_addr [$];
    logic         mon_wrd  [$];
    logic [W-1:0] mon_data [$];
    int           mon_cyc  [$];
    int           done_cyc [$];
    logic [W-1:0] rd_got   [$];

    ram_burst_ctrl_if #(.W(W), .ADDR_LEN(AL)) bus ();

    ram_burst_ctrl #(.W(W), .D(D), .ADDR_LEN(AL)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ram_valid   (ram_valid),
        .ram_wrd     (ram_wrd),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_ready   (ram_ready)
    );

    single_port_ram #(.W(W), .D(D), .ADDR_LEN(AL)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .valid   (ram_valid),
        .wrd     (ram_wrd),
        .address (ram_address),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata),
        .ready   (ram_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every RAM request and done pulse with the cycle it appeared in.
    always @(posedge clk) begin
        #2;
        if (ram_valid === 1'b1) begin
            mon_addr.push_back(ram_address);
            mon_wrd.push_back(ram_wrd);
            mon_data.push_back(ram_wdata);
            mon_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_addr.delete(); mon_wrd.delete(); mon_data.delete();
        mon_cyc.delete(); done_cyc.delete(); rd_got.delete();
    endtask

    task automatic issue_cmd(input logic wr, input logic [AL-1:0] a, input logic [AL:0] l);
        int n = 0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_len = l;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready); end
        acc_cyc = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input logic [W-1:0] base, input int nb, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + W'(i);
            while (bus.wr_ready !== 1'b1 && n < 50) begin tick(); n++; end
            tick();
            bus.wr_valid = 1'b0;
            if (gaps) tick();
        end
    endtask

    task automatic recv_beats(input int nb);
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            while (bus.rd_valid !== 1'b1 && n < 50) begin tick(); n++; end
            rd_got.push_back(bus.rd_data);
            tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ram_valid: got %b want 0", ram_valid); end
        n_checks++; if (ram_wrd !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wrd: got %b want 0", ram_wrd); end
        n_checks++; if (ram_address !== 5'd0) begin n_fail++; $display("FAIL reset_ram_address: got %0d want 0", ram_address); end
        n_checks++; if (ram_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_ram_wdata: got %h want 00", ram_wdata); end
        n_checks++; if (ram_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ready: got %b want 0", ram_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [W-1:0] exp_rd [4];
        exp_rd = '{8'hC0, 8'hC1, 8'h13, 8'h14};
        issue_cmd(1'b1, 4'd8, 5'd4); send_beats(8'h11, 4, 1'b0); wait_idle();
        issue_cmd(1'b1, 4'd8, 5'd4);
        bus.wr_valid = 1'b1;
        bus.wr_data = 8'hC0; tick();
        bus.wr_data = 8'hC1; tick();
        bus.wr_data = 8'hC2; rst = 1'b1; tick();
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ram_valid: got %b want 0", ram_valid); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_ready: got %b want 0", bus.wr_ready); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cmd_ready: got %b want 1", bus.cmd_ready); end
        rst = 1'b0; bus.wr_valid = 1'b0; tick();
        n_checks++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_post_ram_valid: got %b want 0", ram_valid); end
        clear_mon();
        bus.rd_ready = 1'b1;
        issue_cmd(1'b0, 4'd8, 5'd4); recv_beats(4);
        bus.rd_ready = 1'b0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] g;
            g = (i < rd_got.size()) ? rd_got[i] : 'x;
            n_checks++; if (g !== exp_rd[i]) begin n_fail++; $display("FAIL midrst_ram_word%0d: got %h want %h", i, g, exp_rd[i]); end
        end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL midrst_read_done_count: got %0d want 1", done_cyc.size()); end
    endtask

    task automatic test_write_basic();
        clear_mon();
        issue_cmd(1'b1, 4'd3, 5'd4); send_beats(8'hA0, 4, 1'b0); wait_idle();
        n_checks++; if (mon_addr.size() != 4) begin n_fail++; $display("FAIL wr_req_count: got %0d want 4", mon_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [AL:0] ga; logic gw; logic [W-1:0] gd; int gc;
            ga = 'x; gw = 1'bx; gd = 'x; gc = -1;
            if (i < mon_addr.size()) begin ga = mon_addr[i]; gw = mon_wrd[i]; gd = mon_data[i]; gc = mon_cyc[i]; end
            n_checks++; if (ga !== AW'(3 + i)) begin n_fail++; $display("FAIL wr_addr%0d: got %0d want %0d", i, ga, 3 + i); end
            n_checks++; if (gw !== 1'b1) begin n_fail++; $display("FAIL wr_wrd%0d: got %b want 1", i, gw); end
            n_checks++; if (gd !== 8'hA0 + W'(i)) begin n_fail++; $display("FAIL wr_data%0d: got %h want %h", i, gd, 8'hA0 + W'(i)); end
            n_checks++; if (gc != acc_cyc + 2 + i) begin n_fail++; $display("FAIL wr_cycle%0d: got %0d want %0d", i, gc, acc_cyc + 2 + i); end
        end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL wr_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_checks++; if (done_cyc[0] != acc_cyc + 5) begin n_fail++; $display("FAIL wr_done_cycle: got %0d want %0d", done_cyc[0], acc_cyc + 5); end
        end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready_back: got %b want 1", bus.cmd_ready); end
        n_checks++; if (ram_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ram_ready: got %b want 1", ram_ready); end
    endtask

    task automatic test_wrap();
        clear_mon();
        issue_cmd(1'b1, 4'd14, 5'd4); send_beats(8'hB0, 4, 1'b0); wait_idle();
        for (int i = 0; i < 4; i++) begin
            logic [AL:0] ga;
            ga = (i < mon_addr.size()) ? mon_addr[i] : 'x;
            n_checks++; if (ga !== AW'((14 + i) % 16)) begin n_fail++; $display("FAIL wrap_wr_addr%0d: got %0d want %0d", i, ga, (14 + i) % 16); end
        end
        clear_mon();
        bus.rd_ready = 1'b1;
        issue_cmd(1'b0, 4'd14, 5'd4); recv_beats(4);
        bus.rd_ready = 1'b0;
        wait_idle();
        n_checks++; if (mon_addr.size() != 4) begin n_fail++; $display("FAIL wrap_rd_req_count: got %0d want 4", mon_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [AL:0] ga; logic gw; int gc; logic [W-1:0] g;
            ga = 'x; gw = 1'bx; gc = -1;
            if (i < mon_addr.size()) begin ga = mon_addr[i]; gw = mon_wrd[i]; gc = mon_cyc[i]; end
            g = (i < rd_got.size()) ? rd_got[i] : 'x;
            n_checks++; if (ga !== AW'((14 + i) % 16)) begin n_fail++; $display("FAIL wrap_rd_addr%0d: got %0d want %0d", i, ga, (14 + i) % 16); end
            n_checks++; if (gw !== 1'b0) begin n_fail++; $display("FAIL wrap_rd_wrd%0d: got %b want 0", i, gw); end
            n_checks++; if (gc != acc_cyc + 2 + 3 * i) begin n_fail++; $display("FAIL wrap_rd_cycle%0d: got %0d want %0d", i, gc, acc_cyc + 2 + 3 * i); end
            n_checks++; if (g !== 8'hB0 + W'(i)) begin n_fail++; $display("FAIL wrap_rd_data%0d: got %h want %h", i, g, 8'hB0 + W'(i)); end
        end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL wrap_rd_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_checks++; if (done_cyc[0] != acc_cyc + 13) begin n_fail++; $display("FAIL wrap_rd_done_cycle: got %0d want %0d", done_cyc[0], acc_cyc + 13); end
        end
    endtask

    task automatic test_read_stall();
        int n = 0;
        logic [W-1:0] first;
        bus.rd_ready = 1'b0;
        issue_cmd(1'b0, 4'd3, 5'd2);
        while (bus.rd_valid !== 1'b1 && n < 50) begin tick(); n++; end
        clear_mon();
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rd_valid%0d: got %b want 1", k, bus.rd_valid); end
            n_checks++; if (bus.rd_data !== 8'hA0) begin n_fail++; $display("FAIL stall_rd_data%0d: got %h want a0", k, bus.rd_data); end
            tick();
        end
        n_checks++; if (mon_addr.size() != 0) begin n_fail++; $display("FAIL stall_ram_valid_seen: got %0d requests want 0", mon_addr.size()); end
        first = bus.rd_data;
        bus.rd_ready = 1'b1;
        tick();
        recv_beats(1);
        bus.rd_ready = 1'b0;
        wait_idle();
        n_checks++; if (first !== 8'hA0) begin n_fail++; $display("FAIL stall_beat0: got %h want a0", first); end
        n_checks++; if ((rd_got.size() == 1 ? rd_got[0] : 8'hxx) !== 8'hA1) begin n_fail++; $display("FAIL stall_beat1: got %h want a1", rd_got.size() == 1 ? rd_got[0] : 8'hxx); end
    endtask

    task automatic test_zero_len();
        clear_mon();
        for (int r = 0; r < 2; r++) begin
            issue_cmd(r == 0, 4'd5, 5'd0);
            n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_len_done%0d: got %b want 1", r, bus.done); end
            n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL zero_len_wr_ready%0d: got %b want 0", r, bus.wr_ready); end
            n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_rd_valid%0d: got %b want 0", r, bus.rd_valid); end
            tick();
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_len_done_end%0d: got %b want 0", r, bus.done); end
            n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_len_cmd_ready%0d: got %b want 1", r, bus.cmd_ready); end
        end
        bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
                n_fail++; $display("FAIL stray_inputs%0d: cmd_ready=%b wr_ready=%b rd_valid=%b want 1 0 0", k, bus.cmd_ready, bus.wr_ready, bus.rd_valid);
            end
        end
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        tick();
        n_checks++; if (mon_addr.size() != 0) begin n_fail++; $display("FAIL zero_len_ram_valid: got %0d requests want 0", mon_addr.size()); end
        n_checks++; if (done_cyc.size() != 2) begin n_fail++; $display("FAIL zero_len_done_count: got %0d want 2", done_cyc.size()); end
    endtask

    task automatic test_write_gaps();
        clear_mon();
        issue_cmd(1'b1, 4'd10, 5'd4); send_beats(8'hD0, 4, 1'b1); wait_idle();
        n_checks++; if (mon_addr.size() != 4) begin n_fail++; $display("FAIL gap_req_count: got %0d want 4", mon_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [AL:0] ga; logic [W-1:0] gd; int gc;
            ga = 'x; gd = 'x; gc = -1;
            if (i < mon_addr.size()) begin ga = mon_addr[i]; gd = mon_data[i]; gc = mon_cyc[i]; end
            n_checks++; if (ga !== AW'(10 + i)) begin n_fail++; $display("FAIL gap_addr%0d: got %0d want %0d", i, ga, 10 + i); end
            n_checks++; if (gd !== 8'hD0 + W'(i)) begin n_fail++; $display("FAIL gap_data%0d: got %h want %h", i, gd, 8'hD0 + W'(i)); end
            n_checks++; if (gc != acc_cyc + 2 + 2 * i) begin n_fail++; $display("FAIL gap_cycle%0d: got %0d want %0d", i, gc, acc_cyc + 2 + 2 * i); end
        end
        n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL gap_done_count: got %0d want 1", done_cyc.size()); end
        else begin
            n_checks++; if (done_cyc[0] != acc_cyc + 8) begin n_fail++; $display("FAIL gap_done_cycle: got %0d want %0d", done_cyc[0], acc_cyc + 8); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        test_reset();
        test_reset_mid_write();
        test_write_basic();
        test_wrap();
        test_read_stall();
        test_zero_len();
        test_write_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
